// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-ready stall watchdog.
// Optional feature macro: MULTICYCLE_CTRL_JUMP_EN adds the J instruction (JUMP state, pc_src=10).
module multicycle_ctrl #(
  parameter int OPW       = 6,
  parameter int ALUOPW    = 2,
  parameter int STALL_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [ALUOPW-1:0] ALUop,
  output logic              RegDst,
  output logic              ALUsrc,
  output logic              Br,
  output logic              ZeroCheck,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              ir_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic              err_timeout
);

  localparam int CNTW = $clog2(STALL_MAX + 1);

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
`endif

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    EXEC_BR,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    WB_R,
    WB_I,
    WB_MEM,
`ifdef MULTICYCLE_CTRL_JUMP_EN
    JUMP,
`endif
    HALT
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [OPW-1:0]  op_q, op_d;
  logic            stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    err_d      = err_q;
    op_d       = op_q;
    stall      = 1'b0;
    ALUop      = '0;
    RegDst     = 1'b0;
    ALUsrc     = 1'b0;
    Br         = 1'b0;
    ZeroCheck  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else begin
          stall = 1'b1;
        end
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is being decoded.
        ALUsrc = 1'b1;
        op_d   = opcode;
        case (opcode)
          OP_R:           state_d = EXEC_R;
          OP_ADDI:        state_d = EXEC_I;
          OP_BEQ, OP_BNE: state_d = EXEC_BR;
          OP_LW, OP_SW:   state_d = MEM_ADDR;
`ifdef MULTICYCLE_CTRL_JUMP_EN
          OP_J:           state_d = JUMP;
`endif
          default:        state_d = FETCH;
        endcase
      end
      EXEC_R: begin
        ALUop   = ALUOPW'(2'b10);
        state_d = WB_R;
      end
      EXEC_I: begin
        ALUsrc  = 1'b1;
        state_d = WB_I;
      end
      EXEC_BR: begin
        ALUop     = ALUOPW'(2'b01);
        Br        = 1'b1;
        ZeroCheck = (op_q == OP_BEQ);
        pc_write  = (zero == ZeroCheck);
        pc_src    = 2'b01;
        state_d   = FETCH;
      end
      MEM_ADDR: begin
        ALUsrc  = 1'b1;
        state_d = (op_q == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ready) state_d = WB_MEM;
        else           stall   = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        if (mem_ready) state_d = FETCH;
        else           stall   = 1'b1;
      end
      WB_R: begin
        reg_write = 1'b1;
        RegDst    = 1'b1;
        state_d   = FETCH;
      end
      WB_I: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
`ifdef MULTICYCLE_CTRL_JUMP_EN
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = FETCH;
      end
`endif
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    // Watchdog: the STALL_MAX-th consecutive wait cycle parks the FSM in HALT.
    if (stall) begin
      if (cnt_q == CNTW'(STALL_MAX - 1)) begin
        state_d = HALT;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  assign err_timeout = err_q;

endmodule
